// File: rtl/m68k_bus_pkg.sv
// Shared types and address map for the fx68k bus controller.
package m68k_bus_pkg;

    typedef enum logic [2:0] {REG_ROM, REG_RAM, REG_IO, REG_IACK, REG_NONE} region_t;
    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    localparam logic [23:0] ROM_BASE = 24'h000000;
    localparam logic [23:0] ROM_MASK = 24'hFF0000;
    localparam logic [23:0] RAM_BASE = 24'h100000;
    localparam logic [23:0] RAM_MASK = 24'hFF0000;
    localparam logic [23:0] IO_BASE  = 24'h200000;
    localparam logic [23:0] IO_MASK  = 24'hFFFF00;

    // Function code 7 is an interrupt acknowledge regardless of address.
    function automatic region_t decode(input logic [2:0] fc, input logic [23:0] addr);
        if (fc == 3'b111)                       return REG_IACK;
        else if ((addr & ROM_MASK) == ROM_BASE) return REG_ROM;
        else if ((addr & RAM_MASK) == RAM_BASE) return REG_RAM;
        else if ((addr & IO_MASK) == IO_BASE)   return REG_IO;
        else                                    return REG_NONE;
    endfunction

endpackage

// File: rtl/m68k_irq_ctrl.sv
// Vblank interrupt: edge detect, pending flag, IPL encode, clear on matching IACK.
module m68k_irq_ctrl #(
    parameter logic [2:0] IRQ_LEVEL = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vblank,
    input  logic       iack_clr,
    output logic [2:0] cpu_ipl_n
);

    logic vblank_q;
    logic irq_pending;

    // A new vblank edge wins over a simultaneous acknowledge so no frame is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            vblank_q    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (vblank && !vblank_q)
                irq_pending <= 1'b1;
            else if (iack_clr)
                irq_pending <= 1'b0;
        end
    end

    assign cpu_ipl_n = irq_pending ? ~IRQ_LEVEL : 3'b111;

endmodule

// File: rtl/m68k_bus_ctrl.sv
// fx68k bus controller: region decode, wait states, DTACK/VPA, byte strobes, vblank IRQ.
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int         ROM_WAIT  = 1,
    parameter int         RAM_WAIT  = 1,
    parameter int         IO_WAIT   = 2,
    parameter logic [2:0] IRQ_LEVEL = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw,
    input  logic [2:0]  cpu_fc,
    input  logic [22:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_dtack_n,
    output logic        cpu_vpa_n,
    output logic [2:0]  cpu_ipl_n,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] rom_q,
    input  logic [15:0] ram_q,
    output logic [1:0]  ram_we,
    input  logic [15:0] io_q,
    output logic [1:0]  io_we,
    output logic        io_re,
    input  logic        vblank
);

    localparam int MAX_WAIT = (ROM_WAIT > RAM_WAIT) ?
                              ((ROM_WAIT > IO_WAIT) ? ROM_WAIT : IO_WAIT) :
                              ((RAM_WAIT > IO_WAIT) ? RAM_WAIT : IO_WAIT);
    localparam int CW = $clog2(MAX_WAIT) + 1;

    state_t        state;
    region_t       region;
    region_t       dec;
    logic          rd;
    logic [1:0]    bmask;
    logic [CW-1:0] cnt;
    logic [CW-1:0] load_cnt;
    logic          start;
    logic          iack_clr;

    assign dec   = decode(cpu_fc, {cpu_addr, 1'b0});
    assign start = !cpu_as_n && (!cpu_uds_n || !cpu_lds_n);

    // IACK shares the slow IO timing.
    always_comb begin
        load_cnt = CW'(IO_WAIT - 1);
        case (dec)
            REG_ROM: load_cnt = CW'(ROM_WAIT - 1);
            REG_RAM: load_cnt = CW'(RAM_WAIT - 1);
            default: load_cnt = CW'(IO_WAIT - 1);
        endcase
    end

    // The acknowledged level sits on A[3:1], which is mem_addr[2:0].
    assign iack_clr = (state == ACK) && (region == REG_IACK) && (mem_addr[2:0] == IRQ_LEVEL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            region      <= REG_NONE;
            rd          <= 1'b1;
            bmask       <= 2'b00;
            cnt         <= '0;
            cpu_din     <= 16'h0000;
            cpu_dtack_n <= 1'b1;
            cpu_vpa_n   <= 1'b1;
            mem_addr    <= 15'h0000;
            mem_wdata   <= 16'h0000;
            ram_we      <= 2'b00;
            io_we       <= 2'b00;
            io_re       <= 1'b0;
        end else begin
            ram_we <= 2'b00;
            io_we  <= 2'b00;
            io_re  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mem_addr  <= cpu_addr[14:0];
                    mem_wdata <= cpu_dout;
                    region    <= dec;
                    rd        <= cpu_rw;
                    bmask     <= {~cpu_uds_n, ~cpu_lds_n};
                    cnt       <= load_cnt;
                    io_re     <= (dec == REG_IO) && cpu_rw;
                    state     <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    // Strobes are raised on entry to ACK so they last exactly that cycle.
                    if (!rd && region == REG_RAM) ram_we <= bmask;
                    if (!rd && region == REG_IO)  io_we  <= bmask;
                    state <= ACK;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                ACK: begin
                    if (rd) begin
                        case (region)
                            REG_ROM: cpu_din <= rom_q;
                            REG_RAM: cpu_din <= ram_q;
                            REG_IO:  cpu_din <= io_q;
                            default: cpu_din <= 16'hFFFF;
                        endcase
                    end
                    if (region == REG_IACK) cpu_vpa_n   <= 1'b0;
                    else                    cpu_dtack_n <= 1'b0;
                    state <= HOLD;
                end
                HOLD: if (cpu_as_n) begin
                    cpu_dtack_n <= 1'b1;
                    cpu_vpa_n   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    m68k_irq_ctrl #(.IRQ_LEVEL(IRQ_LEVEL)) u_irq (
        .clk       (clk),
        .reset     (reset),
        .vblank    (vblank),
        .iack_clr  (iack_clr),
        .cpu_ipl_n (cpu_ipl_n)
    );

    wait_params_legal: assert property (@(posedge clk)
        ROM_WAIT >= 1 && RAM_WAIT >= 1 && IO_WAIT >= 1 && IRQ_LEVEL != 3'd0);

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Scoreboard bench for m68k_bus_ctrl: directed bus cycles, BRAM models, IRQ and reset cases.
module tb_m68k_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_as_n = 1'b1, cpu_uds_n = 1'b1, cpu_lds_n = 1'b1, cpu_rw = 1'b1;
    logic [2:0]  cpu_fc = 3'b101;
    logic [22:0] cpu_addr = '0;
    logic [15:0] cpu_dout = '0;
    logic [15:0] cpu_din;
    logic        cpu_dtack_n, cpu_vpa_n;
    logic [2:0]  cpu_ipl_n;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] rom_q, ram_q, io_q;
    logic [1:0]  ram_we, io_we;
    logic        io_re;
    logic        vblank = 1'b0;

    always #5 clk = ~clk;

    m68k_bus_ctrl #(.ROM_WAIT(1), .RAM_WAIT(1), .IO_WAIT(2), .IRQ_LEVEL(3'd4)) dut (
        .clk(clk), .reset(reset), .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n),
        .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw), .cpu_fc(cpu_fc), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_dtack_n(cpu_dtack_n),
        .cpu_vpa_n(cpu_vpa_n), .cpu_ipl_n(cpu_ipl_n), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rom_q(rom_q), .ram_q(ram_q), .ram_we(ram_we),
        .io_q(io_q), .io_we(io_we), .io_re(io_re), .vblank(vblank)
    );

    // Memory models: synchronous BRAMs with one cycle of read latency.
    function automatic logic [15:0] rom_word(input logic [14:0] a);
        return (a == 15'h0008) ? 16'h4E71 : (16'hA000 ^ {1'b0, a});
    endfunction

    logic [15:0] ram_m [0:32767];
    always @(posedge clk) begin
        if (ram_we[1]) ram_m[mem_addr][15:8] <= mem_wdata[15:8];
        if (ram_we[0]) ram_m[mem_addr][7:0]  <= mem_wdata[7:0];
        ram_q <= ram_m[mem_addr];
        rom_q <= rom_word(mem_addr);
        io_q  <= {8'hC0, mem_addr[7:0]};
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // acks = {dtack_n, vpa_n} at acknowledge; lat counts falling edges from first
    // sight of AS/DS to first sight of the acknowledge (sampling edge + WAIT + 1).
    typedef struct {
        logic [1:0]  acks;
        logic        chk_din;
        logic [15:0] din;
        int          lat;
        logic [14:0] maddr;
        logic [1:0]  rwe;
        logic [1:0]  iwe;
        logic        ire;
    } exp_t;

    exp_t sb[$];

    logic       in_cyc = 1'b0, acked = 1'b0;
    int         lat = 0, rwe_n = 0, iwe_n = 0, ire_n = 0, io_we_total = 0;
    logic [1:0] rwe_or = '0, iwe_or = '0;

    always @(negedge clk) begin
        exp_t e;
        if (io_we != 2'b00) io_we_total++;
        if (reset) begin
            in_cyc = 1'b0;
        end else if (!in_cyc) begin
            if (!cpu_as_n && (!cpu_uds_n || !cpu_lds_n)) begin
                in_cyc = 1'b1; acked = 1'b0; lat = 0;
                rwe_n = 0; iwe_n = 0; ire_n = 0; rwe_or = '0; iwe_or = '0;
            end
        end else begin
            lat++;
            if (ram_we != 2'b00) begin rwe_n++; rwe_or = rwe_or | ram_we; end
            if (io_we != 2'b00)  begin iwe_n++; iwe_or = iwe_or | io_we; end
            if (io_re) ire_n++;
            if (!acked && (!cpu_dtack_n || !cpu_vpa_n)) begin
                acked = 1'b1;
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack: got ack with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    chk("ack_kind", {cpu_dtack_n, cpu_vpa_n}, e.acks);
                    if (e.chk_din) chk("rd_data", cpu_din, e.din);
                    chk("latency", lat, e.lat);
                    chk("mem_addr", mem_addr, e.maddr);
                    chk("ram_we", rwe_or, e.rwe);
                    chk("ram_we_cycles", rwe_n, (e.rwe != 2'b00));
                    chk("io_we", iwe_or, e.iwe);
                    chk("io_we_cycles", iwe_n, (e.iwe != 2'b00));
                    chk("io_re_cycles", ire_n, e.ire);
                end
            end
            if (cpu_as_n) in_cyc = 1'b0;
        end
    end

    task automatic run_cycle(input logic rw, input logic [2:0] fc, input logic [23:0] ba,
                             input logic un, input logic ln, input logic [15:0] wd, input int hold);
        int n, h;
        @(posedge clk); #1;
        cpu_addr = ba[23:1]; cpu_fc = fc; cpu_rw = rw; cpu_dout = wd;
        cpu_as_n = 1'b0; cpu_uds_n = un; cpu_lds_n = ln;
        n = 0;
        while (cpu_dtack_n && cpu_vpa_n && n < 40) begin @(posedge clk); #1; n++; end
        if (n >= 40) chk("ack_timeout", n, 0);
        h = 0;
        repeat (hold) begin @(negedge clk); if (!cpu_dtack_n || !cpu_vpa_n) h++; end
        if (hold > 0) chk("ack_hold", h, hold);
        @(posedge clk); #1;
        cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
        @(posedge clk); #1;
        chk("ack_release", {cpu_dtack_n, cpu_vpa_n}, 2'b11);
    endtask

    task automatic rd_cyc(input logic [2:0] fc, input logic [23:0] ba, input logic [1:0] acks,
                          input logic cd, input logic [15:0] din, input int lt, input logic ire,
                          input int hold);
        sb.push_back('{acks, cd, din, lt, ba[15:1], 2'b00, 2'b00, ire});
        run_cycle(1'b1, fc, ba, 1'b0, 1'b0, 16'h0000, hold);
    endtask

    task automatic wr_cyc(input logic [23:0] ba, input logic un, input logic ln, input logic [15:0] wd,
                          input logic [1:0] rwe, input logic [1:0] iwe, input int lt);
        sb.push_back('{2'b01, 1'b0, 16'h0000, lt, ba[15:1], rwe, iwe, 1'b0});
        run_cycle(1'b0, 3'b101, ba, un, ln, wd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_din", cpu_din, 16'h0000);
        chk("rst_acks", {cpu_dtack_n, cpu_vpa_n}, 2'b11);
        chk("rst_ipl", cpu_ipl_n, 3'b111);
        chk("rst_we", {ram_we, io_we, io_re}, 5'b0);
        chk("rst_mem", {mem_addr, mem_wdata}, 31'h0);
        @(posedge clk); #1 reset = 1'b0;

        // ROM reads, including last word; ROM write is dropped
        rd_cyc(3'b101, 24'h000010, 2'b01, 1'b1, 16'h4E71, 3, 1'b0, 0);
        rd_cyc(3'b101, 24'h00FFFE, 2'b01, 1'b1, 16'hDFFF, 3, 1'b0, 0);
        wr_cyc(24'h000020, 1'b0, 1'b0, 16'h1111, 2'b00, 2'b00, 3);

        // RAM word then byte writes; reads must show untouched byte lanes
        wr_cyc(24'h100002, 1'b0, 1'b0, 16'h5566, 2'b11, 2'b00, 3);
        wr_cyc(24'h100002, 1'b1, 1'b0, 16'h00AB, 2'b01, 2'b00, 3);
        rd_cyc(3'b101, 24'h100002, 2'b01, 1'b1, 16'h55AB, 3, 1'b0, 0);
        wr_cyc(24'h100002, 1'b0, 1'b1, 16'hCD00, 2'b10, 2'b00, 3);
        rd_cyc(3'b101, 24'h100002, 2'b01, 1'b1, 16'hCDAB, 3, 1'b0, 0);
        wr_cyc(24'h10FFFE, 1'b0, 1'b0, 16'hBEEF, 2'b11, 2'b00, 3);
        rd_cyc(3'b101, 24'h10FFFE, 2'b01, 1'b1, 16'hBEEF, 3, 1'b0, 0);

        // IO and unmapped
        rd_cyc(3'b101, 24'h200010, 2'b01, 1'b1, 16'hC008, 4, 1'b1, 0);
        wr_cyc(24'h200020, 1'b1, 1'b0, 16'h0077, 2'b00, 2'b01, 4);
        rd_cyc(3'b101, 24'h2000FE, 2'b01, 1'b1, 16'hC07F, 4, 1'b1, 0);
        rd_cyc(3'b101, 24'h200100, 2'b01, 1'b1, 16'hFFFF, 4, 1'b0, 0);
        rd_cyc(3'b101, 24'h300000, 2'b01, 1'b1, 16'hFFFF, 4, 1'b0, 0);
        wr_cyc(24'h300000, 1'b0, 1'b0, 16'h2222, 2'b00, 2'b00, 4);

        // AS held for 10 clocks after acknowledge
        rd_cyc(3'b101, 24'h000010, 2'b01, 1'b1, 16'h4E71, 3, 1'b0, 10);

        // vblank interrupt; IACK timed like IO
        @(posedge clk); #1 vblank = 1'b1;
        @(posedge clk); #1;
        chk("ipl_set", cpu_ipl_n, 3'b011);
        rd_cyc(3'b111, 24'hFFFFF4, 2'b10, 1'b0, 16'h0000, 4, 1'b0, 0);
        chk("ipl_other_level", cpu_ipl_n, 3'b011);
        rd_cyc(3'b111, 24'hFFFFF8, 2'b10, 1'b0, 16'h0000, 4, 1'b0, 0);
        chk("ipl_cleared", cpu_ipl_n, 3'b111);

        // New vblank edge on the clearing edge keeps the interrupt pending
        vblank = 1'b0;
        repeat (2) @(posedge clk); #1 vblank = 1'b1;
        repeat (2) @(posedge clk); #1 vblank = 1'b0;
        repeat (2) @(posedge clk);
        chk("ipl_set2", cpu_ipl_n, 3'b011);
        fork
            rd_cyc(3'b111, 24'hFFFFF8, 2'b10, 1'b0, 16'h0000, 4, 1'b0, 0);
            begin repeat (4) @(posedge clk); #1 vblank = 1'b1; end
        join
        chk("irq_set_wins", cpu_ipl_n, 3'b011);
        vblank = 1'b0;
        rd_cyc(3'b111, 24'hFFFFF8, 2'b10, 1'b0, 16'h0000, 4, 1'b0, 0);
        chk("ipl_cleared2", cpu_ipl_n, 3'b111);

        // Reset during WAIT of an IO write abandons the cycle
        snap = io_we_total;
        @(posedge clk); #1;
        cpu_addr = 23'h100020; cpu_fc = 3'b101; cpu_rw = 1'b0; cpu_dout = 16'h3333;
        cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_dtack", cpu_dtack_n, 1'b1);
        chk("rst_mid_mem_addr", mem_addr, 15'h0000);
        cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1; cpu_rw = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("rst_no_io_we", io_we_total - snap, 0);
        chk("rst_dtack_idle", cpu_dtack_n, 1'b1);
        rd_cyc(3'b101, 24'h000010, 2'b01, 1'b1, 16'h4E71, 3, 1'b0, 0);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
